// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and completes loads on the
// memory read response, with one holding slot for an ALU result that collides with a load.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3,
  output logic            pend_valid,
  output logic [4:0]      pend_rd,
  output logic            retired,
  output logic            misalign_err,
  output logic [31:0]     retire_cnt
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cap_rd_q, cap_rd_d;
  logic            cap_wen_q, cap_wen_d;
  logic [2:0]      cap_f3_q, cap_f3_d;
  logic [1:0]      cap_lo_q, cap_lo_d;
  logic            hold_vld_q, hold_vld_d;
  logic [4:0]      hold_rd_q, hold_rd_d;
  logic            hold_wen_q, hold_wen_d;
  logic [XLEN-1:0] hold_data_q, hold_data_d;
  logic            we_q, we_d, ret_q, ret_d, mis_q, mis_d;
  logic [4:0]      wa_q, wa_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            pend_q, pend_d;
  logic [4:0]      pend_rd_q;
  logic [31:0]     cnt_q;
  logic            xfer, ld_done;

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3,
                                                   input logic [1:0] lo,
                                                   input logic [XLEN-1:0] data);
    logic [XLEN-1:0] sh;
    sh = data >> {lo, 3'b000};
    case (f3)
      3'b000:  load_extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: load_extract = data;
    endcase
  endfunction

  // Unsupported funct3 encodings are reported as misaligned.
  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~lo[0];
      3'b010:         load_ok = (lo == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  endfunction

  assign in_ready = ~rst & ~hold_vld_q & ((state_q == S_IDLE) | mem_rvalid);
  assign xfer     = in_valid & in_ready;
  assign ld_done  = (state_q == S_WAIT) & mem_rvalid & ~hold_vld_q;

  always_comb begin
    state_d     = state_q;
    cap_rd_d    = cap_rd_q;
    cap_wen_d   = cap_wen_q;
    cap_f3_d    = cap_f3_q;
    cap_lo_d    = cap_lo_q;
    hold_vld_d  = hold_vld_q;
    hold_rd_d   = hold_rd_q;
    hold_wen_d  = hold_wen_q;
    hold_data_d = hold_data_q;
    we_d        = 1'b0;
    ret_d       = 1'b0;
    mis_d       = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;

    if (hold_vld_q) begin
      ret_d      = 1'b1;
      hold_vld_d = 1'b0;
      if (hold_wen_q && hold_rd_q != 5'd0) begin
        we_d = 1'b1;
        wa_d = hold_rd_q;
        wd_d = hold_data_q;
      end
    end else if (ld_done) begin
      ret_d   = 1'b1;
      state_d = S_IDLE;
      if (!load_ok(cap_f3_q, cap_lo_q)) begin
        mis_d = 1'b1;
      end else if (cap_wen_q && cap_rd_q != 5'd0) begin
        we_d = 1'b1;
        wa_d = cap_rd_q;
        wd_d = load_extract(cap_f3_q, cap_lo_q, mem_rdata);
      end
    end

    if (xfer) begin
      if (in_is_load) begin
        state_d   = S_WAIT;
        cap_rd_d  = in_rd;
        cap_wen_d = in_wen;
        cap_f3_d  = in_funct3;
        cap_lo_d  = in_addr_lo;
      end else if (ld_done) begin
        // The load owns the write port this cycle; park the ALU result.
        hold_vld_d  = 1'b1;
        hold_rd_d   = in_rd;
        hold_wen_d  = in_wen;
        hold_data_d = in_result;
      end else begin
        ret_d = 1'b1;
        if (in_wen && in_rd != 5'd0) begin
          we_d = 1'b1;
          wa_d = in_rd;
          wd_d = in_result;
        end
      end
    end

    pend_d = (state_d == S_WAIT) & cap_wen_d & (cap_rd_d != 5'd0);
  end

  // Control and architecturally visible registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_vld_q <= 1'b0;
      cap_rd_q   <= 5'd0;
      cap_wen_q  <= 1'b0;
      we_q       <= 1'b0;
      ret_q      <= 1'b0;
      mis_q      <= 1'b0;
      wa_q       <= 5'd0;
      wd_q       <= '0;
      pend_q     <= 1'b0;
      pend_rd_q  <= 5'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      cap_rd_q   <= cap_rd_d;
      cap_wen_q  <= cap_wen_d;
      we_q       <= we_d;
      ret_q      <= ret_d;
      mis_q      <= mis_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      pend_q     <= pend_d;
      pend_rd_q  <= cap_rd_d;
      cnt_q      <= cnt_q + {31'd0, ret_d};
    end
  end

  // Payload-only registers, qualified by state/hold_vld
  always_ff @(posedge clk) begin
    cap_f3_q    <= cap_f3_d;
    cap_lo_q    <= cap_lo_d;
    hold_rd_q   <= hold_rd_d;
    hold_wen_q  <= hold_wen_d;
    hold_data_q <= hold_data_d;
  end

  assign we3          = we_q;
  assign wa3          = wa_q;
  assign wd3          = wd_q;
  assign retired      = ret_q;
  assign misalign_err = mis_q;
  assign pend_valid   = pend_q;
  assign pend_rd      = pend_rd_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, all checked
// against a transaction-level model of retirements.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic        in_wen, in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        retired, misalign_err;
  logic [31:0] retire_cnt;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_result(in_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pend_valid(pend_valid), .pend_rd(pend_rd),
    .retired(retired), .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state: one outstanding load, at most one parked ALU result.
  bit          m_pend, m_pwen, m_held, m_hwen;
  bit [4:0]    m_prd, m_hrd;
  bit [2:0]    m_pf3;
  bit [1:0]    m_plo;
  bit [31:0]   m_hdata;
  bit          e_we, e_ret, e_mis;
  bit [4:0]    e_wa;
  bit [31:0]   e_wd, e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int unsigned load_size(input bit [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit [31:0] load_value(input bit [2:0] f3, input bit [1:0] lo,
                                           input bit [31:0] data);
    longint unsigned field;
    int unsigned     bits;
    bits  = 8 * load_size(f3);
    field = (longint'(data) / (64'd1 << (8 * lo))) % (64'd1 << bits);
    if ((f3 == 3'd0 || f3 == 3'd1) && field >= (64'd1 << (bits - 1)))
      field = field + 64'h1_0000_0000 - (64'd1 << bits);
    return field[31:0];
  endfunction

  function automatic bit load_legal(input bit [2:0] f3, input bit [1:0] lo);
    int unsigned sz;
    sz = load_size(f3);
    return (sz != 0) && (int'(lo) % sz == 0);
  endfunction

  task automatic retire(input bit ok, input bit wen, input bit [4:0] rd, input bit [31:0] d);
    e_ret = 1'b1;
    e_cnt = e_cnt + 1;
    if (!ok) e_mis = 1'b1;
    else if (wen && rd != 0) begin
      e_we = 1'b1; e_wa = rd; e_wd = d;
    end
  endtask

  // Applies one clock edge to the model and DUT, then compares every output.
  task automatic cycle(input string tag);
    bit exp_ready, xfer, done;
    exp_ready = !rst && !m_held && (!m_pend || mem_rvalid);
    #1 chk({tag, ".in_ready"}, in_ready, exp_ready);
    xfer = in_valid && exp_ready;
    e_we = 0; e_ret = 0; e_mis = 0; done = 0;
    if (rst) begin
      m_pend = 0; m_pwen = 0; m_prd = 0; m_held = 0;
      e_wa = 0; e_wd = 0; e_cnt = 0;
    end else begin
      if (m_held) begin
        retire(1'b1, m_hwen, m_hrd, m_hdata);
        m_held = 0;
      end else if (m_pend && mem_rvalid) begin
        retire(load_legal(m_pf3, m_plo), m_pwen, m_prd, load_value(m_pf3, m_plo, mem_rdata));
        m_pend = 0; done = 1;
      end
      if (xfer) begin
        if (in_is_load) begin
          m_pend = 1; m_prd = in_rd; m_pwen = in_wen; m_pf3 = in_funct3; m_plo = in_addr_lo;
        end else if (done) begin
          m_held = 1; m_hrd = in_rd; m_hwen = in_wen; m_hdata = in_result;
        end else retire(1'b1, in_wen, in_rd, in_result);
      end
    end
    @(posedge clk); #1;
    chk({tag, ".we3"}, we3, e_we);
    chk({tag, ".wa3"}, wa3, e_wa);
    chk({tag, ".wd3"}, wd3, e_wd);
    chk({tag, ".retired"}, retired, e_ret);
    chk({tag, ".misalign"}, misalign_err, e_mis);
    chk({tag, ".pend_valid"}, pend_valid, m_pend && m_pwen && m_prd != 0);
    chk({tag, ".pend_rd"}, pend_rd, m_prd);
    chk({tag, ".retire_cnt"}, retire_cnt, e_cnt);
  endtask

  task automatic drive(input bit v, input bit ld, input bit [4:0] rd, input bit wen,
                       input bit [2:0] f3, input bit [1:0] lo, input bit [31:0] res,
                       input bit rv, input bit [31:0] rdat);
    in_valid = v; in_is_load = ld; in_rd = rd; in_wen = wen; in_funct3 = f3;
    in_addr_lo = lo; in_result = res; mem_rvalid = rv; mem_rdata = rdat;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle("reset");
    rst = 1'b0;

    // ALU op rd=5
    drive(1, 0, 5'd5, 1, 0, 0, 32'h12345678, 0, 0);
    cycle("alu5");
    chk("alu5.wd3_const", wd3, 32'h12345678);
    chk("alu5.cnt_const", retire_cnt, 32'd1);

    // LB rd=3, addr_lo=2, three wait cycles
    drive(1, 1, 5'd3, 1, 3'd0, 2'd2, 0, 0, 0);
    cycle("lb.issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("lb.wait");
    chk("lb.pend_rd_const", pend_rd, 5'd3);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h00800000);
    cycle("lb.done");
    chk("lb.wd3_const", wd3, 32'hFFFFFF80);

    // LHU addr_lo=2, then misaligned LW
    drive(1, 1, 5'd9, 1, 3'd5, 2'd2, 0, 0, 0);
    cycle("lhu.issue");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF0000);
    cycle("lhu.done");
    chk("lhu.wd3_const", wd3, 32'h0000BEEF);
    drive(1, 1, 5'd10, 1, 3'd2, 2'd1, 0, 0, 0);
    cycle("lw.issue");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    cycle("lw.mis");
    chk("lw.mis_const", misalign_err, 1'b1);

    // rd=0 ALU op
    drive(1, 0, 5'd0, 1, 0, 0, 32'hDEAD0000, 0, 0);
    cycle("alu0");

    // Load completion coinciding with an ALU transfer
    drive(1, 1, 5'd12, 1, 3'd2, 2'd0, 0, 0, 0);
    cycle("coll.issue");
    drive(1, 0, 5'd7, 1, 0, 0, 32'h0BADBEEF, 1, 32'h11223344);
    cycle("coll.load");
    chk("coll.load_wa_const", wa3, 5'd12);
    drive(1, 0, 5'd8, 1, 0, 0, 32'h55555555, 0, 0);
    cycle("coll.alu");
    chk("coll.alu_wa_const", wa3, 5'd7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("coll.idle");

    // Reset in WAIT abandons the load
    drive(1, 1, 5'd4, 1, 3'd0, 2'd0, 0, 0, 0);
    cycle("rstw.issue");
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("rstw.rst");
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h000000FF);
    cycle("rstw.rvalid");
    chk("rstw.cnt_const", retire_cnt, 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit [2:0] f3;
      case ($urandom_range(0, 5))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
        3: f3 = 3'd4; 4: f3 = 3'd5; default: f3 = 3'($urandom);
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 9) < 4,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, 7) != 0, f3, 2'($urandom), $urandom,
            $urandom_range(0, 9) < 4, $urandom);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width of results and register write port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  MEM-stage instruction presented.
REQ-005 SHALL have port in_ready  output  1  stage accepts instruction this cycle.
REQ-006 SHALL have ports in_rd (input, 5), in_wen (input, 1), in_is_load (input, 1), in_funct3 (input, 3), in_addr_lo (input, 2), in_result (input, XLEN): destination, write-enable, load flag, load size, byte offset, ALU result.
REQ-007 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, XLEN): data-memory read response.
REQ-008 SHALL have ports we3 (output, 1), wa3 (output, 5), wd3 (output, XLEN): register-file write port.
REQ-009 SHALL have ports pend_valid (output, 1) and pend_rd (output, 5): outstanding load destination, for decode hazard stall.
REQ-010 SHALL have ports retired (output, 1), misalign_err (output, 1), retire_cnt (output, 32).

Function
REQ-011 SHALL implement FSM states IDLE and WAIT; transfer occurs at rising edge when in_valid and in_ready are both 1.
REQ-012 SHALL drive in_ready = 1 in IDLE, = mem_rvalid in WAIT (combinational).
REQ-013 Non-load transfer in IDLE: SHALL register we3 = in_wen & (in_rd != 0), wa3 = in_rd, wd3 = in_result, retired = 1 in the next cycle; state stays IDLE.
REQ-014 Load transfer: SHALL capture in_rd, in_wen, in_funct3, in_addr_lo and enter WAIT; no write that cycle.
REQ-015 In WAIT with mem_rvalid = 1: SHALL register the extracted load value onto we3/wa3/wd3 with retired = 1 next cycle, and go to IDLE unless a new load transfers the same edge (then stay WAIT with new captures).
REQ-016 A non-load transfer coinciding with load completion: load completion SHALL take the write port that cycle; the non-load result SHALL be written in the following cycle (one-entry holding register), and in_ready SHALL be 0 while the holding register is occupied.
REQ-017 mem_rvalid in IDLE SHALL be ignored.
REQ-018 Load extraction: byte/half selected by addr_lo; LB (000) and LH (001) sign-extend, LBU (100) and LHU (101) zero-extend, LW (010) passes the word.
REQ-019 LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0: SHALL suppress we3, pulse misalign_err and retired with the would-be write cycle.
REQ-020 Any other funct3 on a load SHALL be treated as misaligned per REQ-019.
REQ-021 we3, retired, misalign_err SHALL be single-cycle pulses per instruction; wa3/wd3 hold last value when we3 = 0.
REQ-022 in_rd = 0 or in_wen = 0: we3 SHALL stay 0, retired still pulses.
REQ-023 pend_valid SHALL equal (state == WAIT) & captured wen & (captured rd != 0); pend_rd = captured rd.
REQ-024 retire_cnt SHALL increment by 1 on each cycle retired = 1, wrapping 0xFFFFFFFF -> 0.
REQ-025 Latency: non-load transfer -> we3 one cycle; mem_rvalid edge -> we3 one cycle.
REQ-026 All outputs except in_ready SHALL be registered.

Reset
REQ-027 rst = 1 at a rising edge SHALL force state IDLE, holding register empty, we3 = 0, wa3 = 0, wd3 = 0, retired = 0, misalign_err = 0, pend_valid = 0, pend_rd = 0, retire_cnt = 0.
REQ-028 Reset during WAIT SHALL abandon the load; later mem_rvalid SHALL be ignored.
REQ-029 While rst = 1, in_ready SHALL be 0 and no transfer SHALL occur.

Verification
REQ-030 ALU op rd = 5, result = 0x12345678 -> next cycle we3 = 1, wa3 = 5, wd3 = 0x12345678, retire_cnt = 1.
REQ-031 LB rd = 3, addr_lo = 2, mem_rdata = 0x00800000 after 3 wait cycles -> pend_valid = 1, pend_rd = 3 during wait; then wd3 = 0xFFFFFF80; in_ready = 0 for waits.
REQ-032 LHU addr_lo = 2, mem_rdata = 0xBEEF0000 -> wd3 = 0x0000BEEF; LW addr_lo = 1 -> we3 = 0, misalign_err = 1.
REQ-033 ALU op rd = 0 -> we3 = 0, retired = 1; load completion plus ALU op same edge -> load write, then ALU write next cycle, in_ready = 0 in between.
REQ-034 rst asserted in WAIT, then mem_rvalid = 1 -> no write, retire_cnt = 0; retire_cnt preset via 2^32 retires wraps to 0.
